// File: rtl/lemmings_pkg.sv
// Shared constants for the lemming world model and the lemming controller bench.
package lemmings_pkg;
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_FALL_CYCLES = 3;
  localparam int DEF_DIG_CYCLES  = 2;
  localparam int DEPTH_W         = 4;
  localparam int CNT_W           = 4;

  typedef logic [DEPTH_W-1:0] depth_t;
  typedef logic [CNT_W-1:0]   cnt_t;
endpackage

// File: rtl/lemmings_world.sv
// Terrain model driving a lemming controller: walls, holes, digging and falling.
// Optional move counter on steps when LEMMINGS_WORLD_STEPS_EN is defined.
module lemmings_world
  import lemmings_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FALL_CYCLES = DEF_FALL_CYCLES,
  parameter int DIG_CYCLES  = DEF_DIG_CYCLES,
  parameter int START_POS   = WIDTH / 2
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     walk_left,
  input  logic                     walk_right,
  input  logic                     aaah,
  input  logic                     digging,
  input  logic [WIDTH-1:0]         hole_map,
  output logic                     bump_left,
  output logic                     bump_right,
  output logic                     ground,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic [DEPTH_W-1:0]       depth,
  output logic [15:0]              steps
);
  localparam int PW = $clog2(WIDTH);

  logic [PW-1:0]    pos_q, pos_d;
  depth_t           depth_q, depth_d;
  cnt_t             fall_cnt_q, fall_cnt_d;
  cnt_t             dig_cnt_q, dig_cnt_d;
  logic [WIDTH-1:0] dug_q, dug_d;

  // Falling is decided by the terrain alone; the controller's aaah is informational.
  logic unused_aaah;
  assign unused_aaah = aaah;

  assign ground     = !(((depth_q == '0) && hole_map[pos_q]) || dug_q[pos_q] ||
                        (fall_cnt_q != '0));
  assign bump_left  = (pos_q == '0);
  assign bump_right = (pos_q == PW'(WIDTH - 1));
  assign pos        = pos_q;
  assign depth      = depth_q;

  always_comb begin
    pos_d      = pos_q;
    depth_d    = depth_q;
    fall_cnt_d = fall_cnt_q;
    dig_cnt_d  = '0;
    dug_d      = dug_q;
    if (!ground) begin
      if (fall_cnt_q == CNT_W'(FALL_CYCLES - 1)) begin
        // Landing on a fresh level: previous level's dug columns no longer matter.
        fall_cnt_d = '0;
        dug_d      = '0;
        if (depth_q != '1) depth_d = depth_q + 1'b1;
      end else begin
        fall_cnt_d = fall_cnt_q + 1'b1;
      end
    end else begin
      if (digging) begin
        if (dig_cnt_q == CNT_W'(DIG_CYCLES - 1)) dug_d[pos_q] = 1'b1;
        else                                     dig_cnt_d    = dig_cnt_q + 1'b1;
      end
      if (walk_left && !walk_right && !bump_left)       pos_d = pos_q - 1'b1;
      else if (walk_right && !walk_left && !bump_right) pos_d = pos_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pos_q      <= PW'(START_POS);
      depth_q    <= '0;
      fall_cnt_q <= '0;
      dig_cnt_q  <= '0;
      dug_q      <= '0;
    end else begin
      pos_q      <= pos_d;
      depth_q    <= depth_d;
      fall_cnt_q <= fall_cnt_d;
      dig_cnt_q  <= dig_cnt_d;
      dug_q      <= dug_d;
    end
  end

`ifdef LEMMINGS_WORLD_STEPS_EN
  logic [15:0] steps_q, steps_d;

  always_comb begin
    steps_d = steps_q;
    if ((pos_d != pos_q) && (steps_q != 16'hFFFF)) steps_d = steps_q + 16'd1;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) steps_q <= '0;
    else        steps_q <= steps_d;
  end

  assign steps = steps_q;
`else
  assign steps = '0;
`endif

endmodule

// File: tb/tb_lemmings_world.sv
// Randomised self-checking bench for lemmings_world against a terrain-rules model.
module tb_lemmings_world;
  localparam int W    = 16;
  localparam int FALL = 3;
  localparam int DIG  = 2;
  localparam int SP   = 8;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0;
  logic [W-1:0]  hole_map = '0;
  logic          bump_left, bump_right, ground;
  logic [3:0]    pos;
  logic [3:0]    depth;
  logic [15:0]   steps;

  int checks = 0;
  int errors = 0;

  lemmings_world #(.WIDTH(W), .FALL_CYCLES(FALL), .DIG_CYCLES(DIG), .START_POS(SP)) dut (
    .clk(clk), .areset(areset), .walk_left(walk_left), .walk_right(walk_right),
    .aaah(aaah), .digging(digging), .hole_map(hole_map), .bump_left(bump_left),
    .bump_right(bump_right), .ground(ground), .pos(pos), .depth(depth), .steps(steps)
  );

  always #5 clk = ~clk;

  // Model: airborne time counted down in edges left, dug columns as a bit set.
  int           m_pos, m_depth, m_air, m_dig, m_steps;
  logic [W-1:0] m_dug;

  function automatic bit m_ground();
    return (m_air == 0) && !((m_depth == 0) && hole_map[m_pos]) && !m_dug[m_pos];
  endfunction

  function automatic int exp_steps();
`ifdef LEMMINGS_WORLD_STEPS_EN
    return m_steps;
`else
    return 0;
`endif
  endfunction

  task automatic m_reset();
    m_pos = SP; m_depth = 0; m_air = 0; m_dig = 0; m_dug = '0; m_steps = 0;
  endtask

  task automatic m_edge();
    int np;
    if (!m_ground()) begin
      if (m_air == 0) m_air = FALL;
      m_air--;
      if (m_air == 0) begin
        m_depth = (m_depth < 15) ? m_depth + 1 : 15;
        m_dug   = '0;
      end
      m_dig = 0;
    end else begin
      if (digging) begin
        m_dig++;
        if (m_dig == DIG) begin m_dug[m_pos] = 1'b1; m_dig = 0; end
      end else m_dig = 0;
      np = m_pos;
      if (walk_left && !walk_right && m_pos > 0) np = m_pos - 1;
      else if (walk_right && !walk_left && m_pos < W - 1) np = m_pos + 1;
      if (np != m_pos && m_steps < 65535) m_steps++;
      m_pos = np;
    end
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    m_reset();
    #1;
    areset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    walk_right = 1'b1;
    step(); step();
    walk_right = 1'b0;
    #2 areset = 1'b1;
    m_reset();
    #1;
    checks++;
    if ({pos, depth, ground, bump_left, bump_right} !== {4'(SP), 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: pos=%0d depth=%0d g=%b bl=%b br=%b, want pos=8 depth=0 g=1 bl=0 br=0",
               pos, depth, ground, bump_left, bump_right);
    end
    areset = 1'b0;
    #1;
  endtask

  task automatic test_walls();
    do_reset();
    walk_left = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (pos !== 4'((i >= 8) ? 0 : SP - i)) begin
        errors++; $display("FAIL walls_pos edge %0d: got %0d want %0d", i, pos, (i >= 8) ? 0 : SP - i);
      end
    end
    checks++;
    if (bump_left !== 1'b1 || bump_right !== 1'b0) begin
      errors++; $display("FAIL walls_bump: bl=%b br=%b want bl=1 br=0", bump_left, bump_right);
    end
    walk_left = 1'b0;
  endtask

  task automatic test_hole();
    do_reset();
    hole_map = 16'h0080;
    walk_left = 1'b1;
    step();
    walk_left = 1'b0;
    checks++;
    if (pos !== 4'd7 || ground !== 1'b0) begin
      errors++; $display("FAIL hole_enter: pos=%0d g=%b want pos=7 g=0", pos, ground);
    end
    step(); step(); step();
    checks++;
    if (depth !== 4'd1 || ground !== 1'b1) begin
      errors++; $display("FAIL hole_land: depth=%0d g=%b want depth=1 g=1", depth, ground);
    end
    walk_right = 1'b1; step(); walk_right = 1'b0;
    walk_left = 1'b1; step(); walk_left = 1'b0;
    checks++;
    if (pos !== 4'd7 || ground !== 1'b1 || depth !== 4'd1) begin
      errors++; $display("FAIL hole_ignored_deep: pos=%0d g=%b depth=%0d want 7 1 1", pos, ground, depth);
    end
    // hole_map acts on ground without a clock at level 0
    do_reset();
    hole_map = 16'h0100;
    #1;
    checks++;
    if (ground !== 1'b0) begin
      errors++; $display("FAIL hole_comb: g=%b want 0", ground);
    end
    hole_map = '0;
    #1;
  endtask

  task automatic test_dig();
    do_reset();
    digging = 1'b1;
    step();
    checks++;
    if (ground !== 1'b1) begin
      errors++; $display("FAIL dig_partial: g=%b want 1", ground);
    end
    step();
    digging = 1'b0;
    checks++;
    if (ground !== 1'b0 || pos !== 4'(SP)) begin
      errors++; $display("FAIL dig_open: g=%b pos=%0d want g=0 pos=8", ground, pos);
    end
    step(); step(); step();
    checks++;
    if (depth !== 4'd1 || ground !== 1'b1) begin
      errors++; $display("FAIL dig_land: depth=%0d g=%b want depth=1 g=1", depth, ground);
    end
    // dig plus walk: hole opens behind the lemming, which stays on ground
    digging = 1'b1; step();
    walk_right = 1'b1; step();
    digging = 1'b0; walk_right = 1'b0;
    checks++;
    if (pos !== 4'(SP + 1) || ground !== 1'b1) begin
      errors++; $display("FAIL dig_walk: pos=%0d g=%b want pos=9 g=1", pos, ground);
    end
    walk_left = 1'b1; step(); walk_left = 1'b0;
    checks++;
    if (pos !== 4'(SP) || ground !== 1'b0) begin
      errors++; $display("FAIL dig_walk_back: pos=%0d g=%b want pos=8 g=0", pos, ground);
    end
  endtask

  task automatic test_reset_midfall();
    do_reset();
    hole_map = 16'h0080;
    walk_left = 1'b1; step(); walk_left = 1'b0;
    step();
    #2 areset = 1'b1;
    m_reset();
    #1;
    checks++;
    if (ground !== 1'b1 || depth !== 4'd0 || pos !== 4'(SP)) begin
      errors++; $display("FAIL reset_midfall: g=%b depth=%0d pos=%0d want 1 0 8", ground, depth, pos);
    end
    areset = 1'b0;
    hole_map = '0;
    #1;
  endtask

  task automatic test_steps();
    do_reset();
    walk_right = 1'b1;
    for (int i = 0; i < 5; i++) step();
    walk_left = 1'b1;
    step();
    walk_left = 1'b0; walk_right = 1'b0;
    checks++;
    if (steps !== 16'(exp_steps()) || pos !== 4'(SP + 5)) begin
      errors++; $display("FAIL steps: steps=%0d pos=%0d want steps=%0d pos=13", steps, pos, exp_steps());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      walk_left  = ($urandom_range(0, 2) == 0);
      walk_right = ($urandom_range(0, 2) == 0);
      digging    = ($urandom_range(0, 5) == 0);
      aaah       = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) hole_map = W'($urandom) & W'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      #1;
      checks++;
      if (ground !== m_ground()) begin
        errors++; $display("FAIL rand_ground cyc %0d: got %b want %b", i, ground, m_ground());
      end
      step();
      checks++;
      if ({pos, depth, bump_left, bump_right, steps} !==
          {4'(m_pos), 4'(m_depth), m_pos == 0, m_pos == W - 1, 16'(exp_steps())}) begin
        errors++;
        $display("FAIL rand_state cyc %0d: pos=%0d depth=%0d bl=%b br=%b steps=%0d want %0d %0d %b %b %0d",
                 i, pos, depth, bump_left, bump_right, steps, m_pos, m_depth, m_pos == 0,
                 m_pos == W - 1, exp_steps());
      end
    end
    walk_left = 1'b0; walk_right = 1'b0; digging = 1'b0; aaah = 1'b0; hole_map = '0;
  endtask

  initial begin
    m_reset();
    areset = 1'b1;
    #12 areset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_walls();
    test_hole();
    test_dig();
    test_reset_midfall();
    test_steps();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lemmings_world.md
LEMMINGS_WORLD -- requirements
Module: lemmings_world

Interface
REQ-001 SHALL take parameter WIDTH, default 16: number of terrain columns; legal range 2..32.
REQ-002 SHALL take parameter FALL_CYCLES, default 3: clocks spent airborne per level dropped; legal range 2..15.
REQ-003 SHALL take parameter DIG_CYCLES, default 2: clocks of digging needed to open a column; legal range 2..15.
REQ-004 SHALL take parameter START_POS, default WIDTH/2: column at reset; legal range 0..WIDTH-1.
REQ-005 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port areset  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have ports walk_left, walk_right, aaah, digging  in  1 each  lemming controller outputs.
REQ-008 SHALL have port hole_map  in  WIDTH  bit i high means column i of level 0 has no floor.
REQ-009 SHALL have ports bump_left, bump_right, ground  out  1 each  controller inputs.
REQ-010 SHALL have ports pos  out  $clog2(WIDTH)  and  depth  out  4  current column and level.
REQ-011 SHALL have port steps  out  16  count of completed moves (see Configuration).

Function
REQ-012 SHALL hold these registers: pos, depth, fall_cnt, dig_cnt, and dug (WIDTH bits).
REQ-013 ground SHALL be combinational: NOT((depth==0 AND hole_map[pos]) OR dug[pos] OR fall_cnt!=0).
REQ-014 bump_left SHALL equal (pos==0) and bump_right SHALL equal (pos==WIDTH-1), both combinational.
REQ-015 Move: when ground, walk_left and NOT walk_right and pos!=0, pos SHALL decrement on the edge; the rightward case is symmetric.
REQ-016 No move SHALL occur with both walk inputs high, at a wall, or when ground is low.
REQ-017 Fall: each edge with ground low SHALL increment fall_cnt; at fall_cnt==FALL_CYCLES-1 the edge SHALL clear fall_cnt, saturate-increment depth (max 15) and clear dug, so a fall lasts exactly FALL_CYCLES edges.
REQ-018 At depth>=1, hole_map SHALL be ignored.
REQ-019 Dig: each edge with digging and ground high SHALL increment dig_cnt; at dig_cnt==DIG_CYCLES-1 the edge SHALL set dug[pos] and clear dig_cnt.
REQ-020 dig_cnt SHALL clear on any edge where digging or ground is low.
REQ-021 Dig and walk both asserted SHALL both act; the dig targets the pre-move pos.
REQ-022 aaah SHALL be accepted but SHALL NOT affect state; the model is the authority on falling.
REQ-023 hole_map changes SHALL take effect combinationally on ground.

Reset
REQ-024 areset high SHALL immediately force pos=START_POS, depth=0, fall_cnt=0, dig_cnt=0, dug=0, steps=0.
REQ-025 Reset SHALL take effect even mid-fall or mid-dig; outputs SHALL reflect reset state without waiting for a clock edge.

Configuration
REQ-026 With macro LEMMINGS_WORLD_STEPS_EN defined, steps SHALL increment (saturating at 16'hFFFF) on every edge where pos changes.
REQ-027 Without LEMMINGS_WORLD_STEPS_EN, steps SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-028 Shared package lemmings_pkg SHALL hold the parameter defaults and the depth width constant (4) shared with the lemming controller bench.
REQ-029 The block SHALL be a single module with no sub-module.

Verification (WIDTH=16, FALL_CYCLES=3, DIG_CYCLES=2, START_POS=8, hole_map=0 unless stated)
REQ-030 Reset: assert areset between edges -> pos=8, depth=0, ground=1, bump_left=0, bump_right=0 immediately.
REQ-031 Walls: walk_left held 10 edges -> pos=0 after the 8th edge, then bump_left=1 and pos stays 0.
REQ-032 Hole: hole_map[7]=1, walk_left for 1 edge -> pos=7, ground=0; 3 edges later depth=1, ground=1; walking over column 7 keeps ground=1.
REQ-033 Dig: digging held at pos 8 -> dug[8] set after the 2nd edge, ground=0; 3 edges later depth=1, ground=1, dug=0.
REQ-034 Reset mid-fall: areset at fall_cnt=1 -> ground=1, depth=0, pos=8 before the next edge.
REQ-035 Steps: with LEMMINGS_WORLD_STEPS_EN defined, 5 right moves then 1 bump edge -> steps=5; without the macro -> steps=0.
